ts_read_arbiter: RTL and testbench

//  Shares the single time-surface read port (addr/en -> val, fixed PIPE_DEPTH latency) between
//  NUM_REQ read clients, e.g. the surface flattener and the feature extractor.

---
 rtl/ts_read_arbiter_pkg.sv | 18 +
 rtl/ts_read_arbiter_if.sv | 28 ++
 rtl/ts_read_arbiter_rr_pick.sv | 27 ++
 rtl/ts_read_arbiter.sv | 102 ++++++++++
 tb/tb_ts_read_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_read_arbiter_pkg.sv
// Shared time-surface constants, arbiter state type and one-hot helper.
package ts_read_arbiter_pkg;

    localparam int unsigned PIPE_DEPTH = 2;
    localparam int unsigned NUM_CELLS  = 256;
    localparam int unsigned VALUE_BITS = 8;
    localparam int unsigned MAX_REQ    = 32;

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } ts_arb_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/ts_read_arbiter_if.sv
// Client request/return bus plus the time-surface read port, as seen by the arbiter.
interface ts_read_arbiter_if #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrW     = 8,
    parameter int unsigned ValueBits = 8
);
    logic [NumReq-1:0]       req;
    logic [NumReq*AddrW-1:0] req_addr;
    logic [NumReq-1:0]       req_en;
    logic [NumReq-1:0]       gnt;
    logic [NumReq-1:0]       rvalid;
    logic [ValueBits-1:0]    rdata;
    logic [AddrW-1:0]        ts_addr;
    logic                    ts_en;
    logic [ValueBits-1:0]    ts_val;

    // Clients and memory side.
    modport master (
        output req, req_addr, req_en, ts_val,
        input  gnt, rvalid, rdata, ts_addr, ts_en
    );

    // Arbiter side.
    modport slave (
        input  req, req_addr, req_en, ts_val,
        output gnt, rvalid, rdata, ts_addr, ts_en
    );
endinterface

// File: rtl/ts_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping.
module ts_read_arbiter_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] pick_o,
    output logic            any_o
);

    logic [IdxW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick_o = '0;
        cand   = '0;
        any_o  = |req_i;
        for (int k = int'(N); k >= 1; k--) begin
            cand = IdxW'((32'(last_i) + 32'(k)) % N);
            if (req_i[cand]) begin
                pick_o = cand;
            end
        end
    end

endmodule

// File: rtl/ts_read_arbiter.sv
// Round-robin, burst-locked arbiter for the time-surface read port with tagged data return.
module ts_read_arbiter
    import ts_read_arbiter_pkg::*;
#(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned NumCells  = NUM_CELLS,
    parameter int unsigned ValueBits = VALUE_BITS,
    parameter int unsigned PipeDepth = PIPE_DEPTH,
    localparam int unsigned AddrW = $clog2(NumCells),
    localparam int unsigned TagW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic               clk,
    input  logic               rst,
    ts_read_arbiter_if.slave   bus,
    output logic               busy
);

    ts_arb_state_t     state_q;
    logic [TagW-1:0]   owner_q;
    logic [TagW-1:0]   last_q;
    logic [NumReq-1:0] gnt_q;
    logic [PipeDepth-1:0] v_q;
    logic [TagW-1:0]   tag_q [PipeDepth];

    logic [TagW-1:0]   pick;
    logic              any;

    ts_read_arbiter_rr_pick #(
        .N (NumReq)
    ) u_rr_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= TagW'(NumReq - 1);
            gnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any) begin
                        owner_q <= pick;
                        gnt_q   <= NumReq'(onehot(32'(pick)));
                        state_q <= StLock;
                    end
                end
                StLock: begin
                    if (!bus.req[owner_q]) begin
                        gnt_q   <= '0;
                        last_q  <= owner_q;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Issue mux is combinational so client timing reaches the memory unchanged.
    always_comb begin
        bus.ts_en   = 1'b0;
        bus.ts_addr = '0;
        if (state_q == StLock && bus.req[owner_q] && bus.req_en[owner_q]) begin
            bus.ts_en   = 1'b1;
            bus.ts_addr = bus.req_addr[32'(owner_q) * AddrW +: AddrW];
        end
    end

    // Tag pipeline mirrors the memory latency; no reset-free stages so returns drop on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(PipeDepth); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            v_q[0]   <= bus.ts_en;
            tag_q[0] <= owner_q;
            for (int i = 1; i < int'(PipeDepth); i++) begin
                v_q[i]   <= v_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            bus.rvalid[i] = v_q[PipeDepth-1] && (tag_q[PipeDepth-1] == TagW'(i));
        end
    end

    assign bus.rdata = bus.ts_val;
    assign bus.gnt   = gnt_q;
    assign busy      = (state_q == StLock) || (|v_q);

endmodule

// File: tb/tb_ts_read_arbiter.sv
// Directed bench for ts_read_arbiter with a cycle-level reference model and a memory model.
module tb_ts_read_arbiter;
    import ts_read_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int PD = PIPE_DEPTH;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    ts_read_arbiter_if #(.NumReq(NR), .AddrW(AW), .ValueBits(8)) bus ();

    ts_read_arbiter #(
        .NumReq    (NR),
        .NumCells  (256),
        .ValueBits (8),
        .PipeDepth (PD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    function automatic logic [7:0] memfn(input int a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    // Time-surface memory: value of the addressed cell PD cycles later.
    logic [7:0] mp [PD];
    always @(posedge clk) begin
        mp[0] <= memfn(int'(bus.ts_addr));
        for (int i = 1; i < PD; i++) mp[i] <= mp[i-1];
    end
    assign bus.ts_val = mp[PD-1];

    // Reference model: owner index (-1 = none) and history of issued reads.
    typedef struct {
        bit v;
        int tag;
        int addr;
    } iss_t;

    int   m_owner = -1;
    int   m_last  = NR - 1;
    iss_t hist [PD];

    function automatic bit exp_en();
        return (m_owner >= 0) && (bus.req[m_owner] === 1'b1) && (bus.req_en[m_owner] === 1'b1);
    endfunction

    function automatic int exp_addr();
        if (!exp_en()) return 0;
        return int'(bus.req_addr[m_owner*AW +: AW]);
    endfunction

    function automatic int rr_next();
        for (int k = 1; k <= NR; k++) begin
            if (bus.req[(m_last + k) % NR] === 1'b1) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    function automatic iss_t make_iss();
        iss_t s;
        s.v    = exp_en();
        s.tag  = (m_owner < 0) ? 0 : m_owner;
        s.addr = exp_addr();
        return s;
    endfunction

    function automatic bit exp_busy();
        bit b = (m_owner >= 0);
        for (int i = 0; i < PD; i++) b = b | hist[i].v;
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_last  <= NR - 1;
            for (int i = 0; i < PD; i++) hist[i] <= '{v: 1'b0, tag: 0, addr: 0};
        end else begin
            hist[0] <= make_iss();
            for (int i = 1; i < PD; i++) hist[i] <= hist[i-1];
            if (m_owner < 0) begin
                m_owner <= rr_next();
            end else if (bus.req[m_owner] !== 1'b1) begin
                m_last  <= m_owner;
                m_owner <= -1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    int             rv0_cnt   = 0;
    int             rv1_cnt   = 0;
    int             rv_cnt    = 0;
    int             first_rd0 = -1;
    int             gseq [$];
    logic [NR-1:0]  gprev     = '0;

    // Compare just before each active edge, after inputs have settled.
    always @(negedge clk) begin
        #3;
        chk("gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("ts_en", 32'(bus.ts_en), 32'(exp_en()));
        chk("ts_addr", 32'(bus.ts_addr), 32'(exp_addr()));
        chk("rvalid", 32'(bus.rvalid), hist[PD-1].v ? (32'd1 << hist[PD-1].tag) : 32'd0);
        chk("busy", 32'(busy), 32'(exp_busy()));
        if (hist[PD-1].v) chk("rdata", 32'(bus.rdata), 32'(memfn(hist[PD-1].addr)));
        if (bus.rvalid[0] === 1'b1) begin
            if (first_rd0 < 0) first_rd0 = int'(bus.rdata);
            rv0_cnt++;
        end
        if (bus.rvalid[1] === 1'b1) rv1_cnt++;
        if (|bus.rvalid) rv_cnt++;
        if (bus.gnt != '0 && gprev == '0) gseq.push_back($clog2(bus.gnt));
        gprev = bus.gnt;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int base;
    int exp_seq [4] = '{0, 1, 0, 1};

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_en   = '0;
        bus.req_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_gnt", 32'(bus.gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Full-surface scan by client 0.
        bus.req = 2'b01;
        tick();
        chk("t1_gnt_latency", 32'(bus.gnt), 32'd1);
        for (int a = 0; a < 256; a++) begin
            bus.req_en        = 2'b01;
            bus.req_addr[7:0] = 8'(a);
            tick();
        end
        bus.req    = '0;
        bus.req_en = '0;
        repeat (4) tick();
        chk("t1_rv0_count", 32'(rv0_cnt), 32'd256);
        chk("t1_first_rdata", 32'(first_rd0), 32'd11);

        // Both request; client 1 issues while client 0 owns the port.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 2'b11;
        tick();
        chk("t2_first_gnt", 32'(bus.gnt), 32'd1);
        base = rv1_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.req_en   = 2'b11;
            bus.req_addr = {8'(200 + i), 8'(10 + i)};
            tick();
        end
        bus.req    = 2'b10;
        bus.req_en = 2'b00;
        tick();
        chk("t2_release_gnt", 32'(bus.gnt), 32'd0);
        chk("t4_rv1_quiet", 32'(rv1_cnt - base), 32'd0);
        tick();
        chk("t2_second_gnt", 32'(bus.gnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            bus.req_en   = 2'b10;
            bus.req_addr = {8'(100 + i), 8'd50};
            tick();
        end
        bus.req    = '0;
        bus.req_en = '0;
        repeat (4) tick();
        chk("t3_rv1_count", 32'(rv1_cnt - base), 32'd4);

        // Reset with reads in flight.
        bus.req = 2'b01;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.req_en   = 2'b01;
            bus.req_addr = {8'd0, 8'(30 + i)};
            tick();
        end
        rst = 1'b1;
        tick();
        chk("t5_gnt", 32'(bus.gnt), 32'd0);
        chk("t5_ts_en", 32'(bus.ts_en), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        rst        = 1'b0;
        bus.req    = '0;
        bus.req_en = '0;
        base       = rv_cnt;
        repeat (4) tick();
        chk("t5_no_rvalid", 32'(rv_cnt - base), 32'd0);

        // Immediate re-request after release waits behind the other client.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gseq.delete();
        bus.req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            int w;
            int own;
            w = 0;
            while (bus.gnt == '0 && w < 5) begin
                tick();
                w++;
            end
            if (bus.gnt == '0) begin
                chk("t6_grant_timeout", 32'd0, 32'd1);
                break;
            end
            own = $clog2(bus.gnt);
            bus.req_en = NR'(1) << own;
            bus.req_addr = {8'(60 + b), 8'(60 + b)};
            tick();
            tick();
            bus.req_en   = '0;
            bus.req[own] = 1'b0;
            tick();
            bus.req[own] = 1'b1;
        end
        bus.req = '0;
        repeat (4) tick();
        chk("t6_burst_count", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) begin
            chk("t6_grant_order", 32'(gseq[i]), 32'(exp_seq[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
